// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_unit
// Purpose  : Front end of the core. Owns the PC and fetches one instruction at
//            a time from instruction memory. It keeps at most one fetch
//            outstanding. It decodes the returned word into a registered bundle
//            and offers that bundle to the execute side with valid/ready.
//
// Ports    : clk, rst              - clock, synchronous active-high reset
//            imem_req_valid_o/     - fetch request handshake; imem_addr_o = PC
//            imem_req_ready_i
//            imem_addr_o
//            imem_rsp_valid_i/     - one-cycle instruction word return
//            imem_rsp_data_i
//            redirect_valid_i/     - load a new PC from the back end; the low
//            redirect_pc_i           two bits are forced to zero
//            dec_valid_o/          - decoded bundle handshake
//            dec_ready_i
//            dec_pc_o, rs1_o,      - decoded bundle fields
//            rs2_o, rd_o, imm_o,
//            opcode_o, mnemonic_o
//            illegal_o             - unsupported instruction flag
//
// Mnemonic : 2'd0 INVALID, 2'd1 ADD, 2'd2 ADDI
//
// Config   : ILLEGAL_TRAP_EN - when this macro is defined, an INVALID bundle
//            raises illegal_o. Once that bundle is consumed, the unit halts
//            until a redirect arrives. When the macro is undefined,
//            illegal_o is tied low and fetch simply continues.
//
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [31:0]           imem_rsp_data_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [ADDR_WIDTH-1:0] dec_pc_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic [4:0]            rd_o,
  output logic [31:0]           imm_o,
  output logic [6:0]            opcode_o,
  output logic [1:0]            mnemonic_o,
  output logic                  illegal_o
);

  localparam logic [1:0] c_ST_REQ  = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_HOLD = 2'd2;
  localparam logic [1:0] c_ST_HALT = 2'd3;

  localparam logic [1:0] c_MNEM_INVALID = 2'd0;
  localparam logic [1:0] c_MNEM_ADD     = 2'd1;
  localparam logic [1:0] c_MNEM_ADDI    = 2'd2;

  localparam logic [6:0] c_OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] c_OP_I_TYPE = 7'b0010011;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  // Set when the outstanding fetch belongs to a PC that has since been
  // redirected away from; its response must be swallowed.
  logic                  squash_q, squash_d;

  logic [ADDR_WIDTH-1:0] dec_pc_q, dec_pc_d;
  logic [4:0]            rs1_q, rs1_d;
  logic [4:0]            rs2_q, rs2_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           imm_q, imm_d;
  logic [6:0]            opcode_q, opcode_d;
  logic [1:0]            mnem_q, mnem_d;
`ifdef ILLEGAL_TRAP_EN
  logic                  illegal_q, illegal_d;
`endif

  // --------------------------------------------------------------------------
  // Decode of the word currently on the response bus
  // --------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_is_add;
  logic        w_is_addi;
  logic [1:0]  w_mnem;
  logic [31:0] w_imm;

  assign w_opcode  = imem_rsp_data_i[6:0];
  assign w_funct3  = imem_rsp_data_i[14:12];
  assign w_funct7  = imem_rsp_data_i[31:25];
  assign w_is_add  = (w_opcode == c_OP_R_TYPE) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0);
  assign w_is_addi = (w_opcode == c_OP_I_TYPE) && (w_funct3 == 3'b000);

  always_comb begin
    w_mnem = c_MNEM_INVALID;
    w_imm  = 32'h0;
    if (w_is_add) begin
      w_mnem = c_MNEM_ADD;
    end else if (w_is_addi) begin
      w_mnem = c_MNEM_ADDI;
      w_imm  = {{20{imem_rsp_data_i[31]}}, imem_rsp_data_i[31:20]};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; a redirect overrides every other transition
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    dec_pc_d = dec_pc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    opcode_d = opcode_q;
    mnem_d   = mnem_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif

    if (redirect_valid_i) begin
      pc_d = redirect_pc_i & ~ADDR_WIDTH'(3);
`ifdef ILLEGAL_TRAP_EN
      illegal_d = 1'b0;
`endif
      case (state_q)
        c_ST_REQ: begin
          // A request accepted this cycle is already in flight for the old PC.
          if (imem_req_ready_i) begin
            state_d  = c_ST_WAIT;
            squash_d = 1'b1;
          end
        end
        c_ST_WAIT: begin
          if (imem_rsp_valid_i) begin
            state_d  = c_ST_REQ;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end
        default: state_d = c_ST_REQ;
      endcase
    end else begin
      case (state_q)
        c_ST_REQ: begin
          if (imem_req_ready_i) begin
            state_d = c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (imem_rsp_valid_i) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = c_ST_REQ;
            end else begin
              dec_pc_d = pc_q;
              rs1_d    = imem_rsp_data_i[19:15];
              rs2_d    = imem_rsp_data_i[24:20];
              rd_d     = imem_rsp_data_i[11:7];
              imm_d    = w_imm;
              opcode_d = w_opcode;
              mnem_d   = w_mnem;
`ifdef ILLEGAL_TRAP_EN
              illegal_d = (w_mnem == c_MNEM_INVALID);
`endif
              state_d  = c_ST_HOLD;
            end
          end
        end
        c_ST_HOLD: begin
          if (dec_ready_i) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
`ifdef ILLEGAL_TRAP_EN
            state_d = illegal_q ? c_ST_HALT : c_ST_REQ;
`else
            state_d = c_ST_REQ;
`endif
          end
        end
        c_ST_HALT: state_d = c_ST_HALT;
        default:   state_d = c_ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= c_ST_REQ;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      dec_pc_q <= '0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      rd_q     <= 5'd0;
      imm_q    <= 32'h0;
      opcode_q <= 7'd0;
      mnem_q   <= c_MNEM_INVALID;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      dec_pc_q <= dec_pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      opcode_q <= opcode_d;
      mnem_q   <= mnem_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The reset state is REQ. The request is masked while reset is held, so
  // the first request appears in the cycle after reset is released.
  assign imem_req_valid_o = (state_q == c_ST_REQ) && !rst;
  assign imem_addr_o      = pc_q;
  assign dec_valid_o      = (state_q == c_ST_HOLD);
  assign dec_pc_o         = dec_pc_q;
  assign rs1_o            = rs1_q;
  assign rs2_o            = rs2_q;
  assign rd_o             = rd_q;
  assign imm_o            = imm_q;
  assign opcode_o         = opcode_q;
  assign mnemonic_o       = mnem_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_o        = illegal_q;
`else
  assign illegal_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_unit
// Purpose  : Directed bench for fetch_decode_unit. The bench contains a small
//            instruction memory with programmable response latency. It also
//            keeps a transaction-level reference model. Each cycle, that
//            model predicts request, address, bundle and illegal outputs.
//            Literal expectations pin the model to hand-decoded words.
//            A second instance starts at PC 0xFFFF_FFFC and checks PC
//            wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_unit;

  localparam logic [1:0] M_INVALID = 2'd0;
  localparam logic [1:0] M_ADD     = 2'd1;
  localparam logic [1:0] M_ADDI    = 2'd2;
`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, redir_valid, dec_valid, dec_ready, illegal;
  logic [31:0] addr, rsp_data, redir_pc, dec_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [1:0]  mnem;

  // second instance (wrap-around PC)
  logic        req_valid2, rsp_valid2, dec_valid2, illegal2;
  logic        one, zero;
  logic [31:0] addr2, rsp_data2, dec_pc2, imm2, zero32;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [6:0]  opcode2;
  logic [1:0]  mnem2;

  fetch_decode_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_valid_i(redir_valid), .redirect_pc_i(redir_pc),
    .dec_valid_o(dec_valid), .dec_ready_i(dec_ready), .dec_pc_o(dec_pc),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm_o(imm), .opcode_o(opcode),
    .mnemonic_o(mnem), .illegal_o(illegal)
  );

  fetch_decode_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(req_valid2), .imem_req_ready_i(one), .imem_addr_o(addr2),
    .imem_rsp_valid_i(rsp_valid2), .imem_rsp_data_i(rsp_data2),
    .redirect_valid_i(zero), .redirect_pc_i(zero32),
    .dec_valid_o(dec_valid2), .dec_ready_i(one), .dec_pc_o(dec_pc2),
    .rs1_o(rs1_2), .rs2_o(rs2_2), .rd_o(rd_2), .imm_o(imm2), .opcode_o(opcode2),
    .mnemonic_o(mnem2), .illegal_o(illegal2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory / logs ----------------
  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mn;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] req_log[$];
  logic [31:0] req_log2[$];
  int          mem_delay, pend;
  logic [31:0] pend_addr;
  logic        stray;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h002081B3; // add  x3, x1, x2
      32'h004: return 32'hFFF00293; // addi x5, x0, -1
      32'h008: return 32'h00000073; // ecall
      32'h100: return 32'h00508093; // addi x1, x1, 5
      32'h104: return 32'h002081B3; // add  x3, x1, x2
      default: return 32'h00000013; // nop
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic        chk_en;
  logic        in_flight, stale, hold, halted;
  logic [31:0] m_pc;
  acc_t        e;
  logic [6:0]  e_op;

  task automatic model_decode(input logic [31:0] w, input logic [31:0] pc);
    logic [31:0] f12;
    e.pc  = pc;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e_op  = w[6:0];
    e.mn  = M_INVALID;
    e.imm = 32'h0;
    f12   = {20'h0, w[31:20]};
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) e.mn = M_ADD;
    else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      e.mn  = M_ADDI;
      e.imm = (f12 >= 32'h800) ? f12 - 32'h1000 : f12;
    end
    e.ill = TRAP && (e.mn == M_INVALID);
  endtask

  task automatic cycle();
    logic        s_rst, s_redir, s_rsp, s_dready, s_hs, s_hs2;
    logic [31:0] s_rpc, s_data, s_addr;
    logic        exp_req;
    @(negedge clk);
    s_rst = rst;  s_redir = redir_valid;  s_rpc = redir_pc;
    s_rsp = rsp_valid;  s_data = rsp_data;  s_dready = dec_ready;
    s_hs  = req_valid && req_ready;  s_addr = addr;  s_hs2 = req_valid2;
    if (chk_en) begin
      exp_req = !s_rst && !in_flight && !hold && !halted;
      chk("req_valid", {31'h0, req_valid}, {31'h0, exp_req});
      if (exp_req) chk("imem_addr", addr, m_pc);
      chk("dec_valid", {31'h0, dec_valid}, {31'h0, hold});
      if (hold) begin
        chk("dec_pc", dec_pc, e.pc);
        chk("rs1", {27'h0, rs1}, {27'h0, e.rs1});
        chk("rs2", {27'h0, rs2}, {27'h0, e.rs2});
        chk("rd", {27'h0, rd}, {27'h0, e.rd});
        chk("imm", imm, e.imm);
        chk("opcode", {25'h0, opcode}, {25'h0, e_op});
        chk("mnemonic", {30'h0, mnem}, {30'h0, e.mn});
      end
      chk("illegal", {31'h0, illegal}, {31'h0, hold ? e.ill : halted});
    end
    if (s_hs) req_log.push_back(s_addr);
    if (s_hs2 && !s_rst) req_log2.push_back(addr2);
    if (dec_valid && dec_ready && !s_rst)
      acc_q.push_back('{pc: dec_pc, mn: mnem, rs1: rs1, rs2: rs2, rd: rd, imm: imm, ill: illegal});
    @(posedge clk);
    if (s_rst) begin
      chk_en = 1'b1;
      in_flight = 1'b0; stale = 1'b0; hold = 1'b0; halted = 1'b0; m_pc = 32'h0;
    end else if (s_redir) begin
      m_pc = s_rpc & ~32'h3;
      if (s_hs) begin in_flight = 1'b1; stale = 1'b1; end
      else if (in_flight && s_rsp) begin in_flight = 1'b0; stale = 1'b0; end
      else if (in_flight) stale = 1'b1;
      hold = 1'b0; halted = 1'b0;
    end else begin
      if (s_hs) begin in_flight = 1'b1; stale = 1'b0; end
      else if (in_flight && s_rsp) begin
        in_flight = 1'b0;
        if (!stale) begin hold = 1'b1; model_decode(s_data, m_pc); end
        stale = 1'b0;
      end else if (hold && s_dready) begin
        hold = 1'b0; m_pc = m_pc + 32'd4; halted = e.ill;
      end
    end
    #1;
    rsp_valid = 1'b0;
    rsp_data  = 32'hDEAD_BEEF;
    if (s_hs) begin pend = mem_delay; pend_addr = s_addr; end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin rsp_valid = 1'b1; rsp_data = mem_word(pend_addr); end
    end
    if (stray) begin rsp_valid = 1'b1; rsp_data = 32'h002081B3; end
    rsp_valid2 = s_hs2 && !s_rst;
  endtask

  function automatic int find_acc(input logic [31:0] pc);
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i].pc == pc) return i;
    return -1;
  endfunction

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req_valid && n < 40) begin cycle(); n++; end
    chk(tag, {31'h0, req_valid}, 32'h1);
  endtask

  task automatic wait_dec(input string tag);
    int n = 0;
    while (!dec_valid && n < 40) begin cycle(); n++; end
    chk(tag, {31'h0, dec_valid}, 32'h1);
  endtask

  initial begin
    int idx, n0;
    one = 1'b1; zero = 1'b0; zero32 = 32'h0; rsp_data2 = 32'h00000013; rsp_valid2 = 1'b0;
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
    redir_valid = 1'b0; redir_pc = 32'h0; dec_ready = 1'b1;
    mem_delay = 1; pend = 0; pend_addr = 32'h0; stray = 1'b0; chk_en = 1'b0;
    in_flight = 1'b0; stale = 1'b0; hold = 1'b0; halted = 1'b0; m_pc = 32'h0;
    e = '{pc: 32'h0, mn: M_INVALID, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'h0, ill: 1'b0};
    e_op = 7'd0;
    cycle(); cycle();
    chk("rst dec_valid", {31'h0, dec_valid}, 32'h0);
    chk("rst req_valid", {31'h0, req_valid}, 32'h0);
    chk("rst mnemonic", {30'h0, mnem}, {30'h0, M_INVALID});
    chk("rst imm", imm, 32'h0);
    chk("rst rd", {27'h0, rd}, 32'h0);
    chk("rst illegal", {31'h0, illegal}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first req_valid", {31'h0, req_valid}, 32'h1);
    chk("first addr", addr, 32'h0);

    // basic stream: add, addi, ecall
    repeat (12) cycle();
    chk("t1 bundle count", {31'h0, acc_q.size() >= 3}, 32'h1);
    chk("t1 add pc", acc_q[0].pc, 32'h0);
    chk("t1 add mnem", {30'h0, acc_q[0].mn}, {30'h0, M_ADD});
    chk("t1 add rs1", {27'h0, acc_q[0].rs1}, 32'd1);
    chk("t1 add rs2", {27'h0, acc_q[0].rs2}, 32'd2);
    chk("t1 add rd", {27'h0, acc_q[0].rd}, 32'd3);
    chk("t1 add imm", acc_q[0].imm, 32'h0);
    chk("t1 addi pc", acc_q[1].pc, 32'h4);
    chk("t1 addi mnem", {30'h0, acc_q[1].mn}, {30'h0, M_ADDI});
    chk("t1 addi rd", {27'h0, acc_q[1].rd}, 32'd5);
    chk("t1 addi imm", acc_q[1].imm, 32'hFFFF_FFFF);
    chk("t6 ecall mnem", {30'h0, acc_q[2].mn}, {30'h0, M_INVALID});
    chk("t6 ecall illegal", {31'h0, acc_q[2].ill}, {31'h0, TRAP});
    chk("t6 request count", req_log.size(), TRAP ? 32'd3 : 32'd4);
    chk("t6 req_valid after ecall", {31'h0, req_valid}, {31'h0, ~TRAP});
    chk("t6 illegal held", {31'h0, illegal}, {31'h0, TRAP});
    chk("t5 wrap first addr", req_log2[0], 32'hFFFF_FFFC);
    chk("t5 wrap next addr", req_log2[1], 32'h0000_0000);

    // redirect from HALT (trap) or from REQ-with-handshake (no trap)
    redir_valid = 1'b1; redir_pc = 32'h100;
    cycle();
    redir_valid = 1'b0;
    n0 = 0;
    while (find_acc(32'h100) < 0 && n0 < 40) begin cycle(); n0++; end
    idx = find_acc(32'h100);
    chk("redir bundle found", {31'h0, idx >= 0}, 32'h1);
    chk("redir addi imm", acc_q[idx].imm, 32'd5);
    chk("redir addi rd", {27'h0, acc_q[idx].rd}, 32'd1);

    // memory stalls the request for 3 cycles
    wait_req("t3 wait req");
    req_ready = 1'b0;
    n0 = req_log.size();
    repeat (3) begin
      cycle();
      chk("t3 req_valid held", {31'h0, req_valid}, 32'h1);
      chk("t3 addr held", addr, 32'h104);
    end
    req_ready = 1'b1;
    cycle();
    chk("t3 single accept", req_log.size() - n0, 32'd1);

    // execute side stalls for 5 cycles, with a stray response mid-stall
    dec_ready = 1'b0;
    wait_dec("t2 wait dec");
    for (int i = 0; i < 5; i++) begin
      stray = (i == 2);
      cycle();
      chk("t2 dec_valid held", {31'h0, dec_valid}, 32'h1);
      chk("t2 dec_pc stable", dec_pc, 32'h104);
      chk("t2 no request", {31'h0, req_valid}, 32'h0);
    end
    stray = 1'b0;
    dec_ready = 1'b1;
    cycle();

    // redirect while waiting on a slow response
    mem_delay = 3;
    wait_req("t4 wait req");
    n0 = req_log.size();
    cycle();
    redir_valid = 1'b1; redir_pc = 32'h0000_0103;
    cycle();
    redir_valid = 1'b0;
    repeat (8) cycle();
    chk("t4 stale dropped", {31'h0, find_acc(req_log[n0]) < 0}, 32'h1);
    chk("t4 next addr", req_log[n0 + 1], 32'h100);

    // redirect in the same cycle as the response
    mem_delay = 1;
    acc_q.delete();
    wait_req("t4b wait req");
    n0 = req_log.size();
    cycle();
    redir_valid = 1'b1; redir_pc = 32'h200;
    cycle();
    redir_valid = 1'b0;
    repeat (6) cycle();
    chk("t4b word dropped", {31'h0, find_acc(req_log[n0]) < 0}, 32'h1);
    chk("t4b next addr", req_log[n0 + 1], 32'h200);

    // redirect while a bundle is being consumed
    wait_dec("t7 wait dec");
    idx = acc_q.size();
    n0 = req_log.size();
    redir_valid = 1'b1; redir_pc = 32'h300;
    cycle();
    redir_valid = 1'b0;
    chk("t7 bundle consumed", acc_q.size() - idx, 32'd1);
    repeat (4) cycle();
    chk("t7 next addr", req_log[n0], 32'h300);

    // reset while a response is in flight
    wait_req("t8 wait req");
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("t8 req after reset", {31'h0, req_valid}, 32'h1);
    chk("t8 addr after reset", addr, 32'h0);
    chk("t8 dec_valid after reset", {31'h0, dec_valid}, 32'h0);
    repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
